i2c_domain_arbiter: RTL and testbench
=====================================

I2C_DOMAIN_ARBITER -- requirements
Module: i2c_domain_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16'd4096: maximum WAIT cycles before a transaction is aborted.
REQ-002 SHALL have parameter SCRUB_CYCLES, default 4'd8: idle cycles inserted after every transaction before the next grant.
REQ-003 SHALL have one clock and an asynchronous, active-high reset, named as follows:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have the remaining ports:
- req0  in  1  domain-0 read request (level).
- addr0  in  7  domain-0 slave address.
- gnt0  out  1  domain-0 owns the I2C subsystem.
- valid0  out  1  domain-0 read data valid (pulse).
- data0  out  8  domain-0 read data.
- req1  in  1  domain-1 read request (level).
- addr1  in  7  domain-1 slave address.
- gnt1  out  1  domain-1 owns the I2C subsystem.
- valid1  out  1  domain-1 read data valid (pulse).
- data1  out  8  domain-1 read data.
- sys_start  out  1  start pulse to the I2C sequencer.
- sys_addr  out  7  slave address to the sequencer.
- sys_domain  out  1  current owner; drives the sequencer, master and slave-bus mux.
- sys_done  in  1  sequencer completion pulse.
- sys_data  in  8  sequencer read data.
- busy  out  1  state not IDLE.
- timeout  out  1  abort pulse.

Function
REQ-005 SHALL implement the states IDLE, START, WAIT and SCRUB, held in one registered state variable.
REQ-006 IDLE SHALL behave as follows:
- If any request is high, go to START at the next edge.
- Latch the winner into owner, and latch its address into sys_addr.
REQ-007 Arbitration SHALL be round-robin:
- A single requester wins.
- On simultaneous req0/req1, the requester not served last wins.
- The last-served pointer resets to 1, so domain 0 wins the first tie.
REQ-008 START SHALL last exactly 1 cycle, with sys_start=1 in that cycle only, then go to WAIT.
REQ-009 gnt<owner> SHALL be 1 from the START cycle through the cycle that completes WAIT; the other grant SHALL be 0.
REQ-010 sys_domain SHALL equal owner in START, WAIT and SCRUB, and SHALL hold its last value in IDLE.
REQ-011 WAIT SHALL behave as follows:
- A cycle counter is cleared on entry.
- On sys_done=1: next cycle valid<owner>=1 and data<owner>=sys_data for exactly 1 cycle; go to SCRUB; update the last-served pointer.
REQ-012 WAIT SHALL abort when the counter reaches TIMEOUT-1 without sys_done:
- timeout=1 for 1 cycle.
- valid<owner> stays 0.
- Go to SCRUB and update the pointer.
REQ-013 data0/data1 SHALL be 8'h00 in every cycle except their own valid cycle; the non-owner's data and valid SHALL never change during a transaction.
REQ-014 SCRUB SHALL hold for SCRUB_CYCLES cycles, with sys_start=0 and no grant asserted, then go to IDLE.
REQ-015 Request handling SHALL follow these rules:
- Requests are sampled only in IDLE.
- Deassertion of req or changes to addr after the grant are ignored.
- A request still high after SCRUB is re-arbitrated.
REQ-016 sys_done SHALL be ignored in IDLE, START and SCRUB.
REQ-017 If sys_done and the timeout terminal count coincide, sys_done SHALL win, with valid asserted and timeout not asserted.
REQ-018 busy SHALL be 1 in START, WAIT and SCRUB.

Reset
REQ-019 On rst=1, asynchronously:
- state=IDLE, owner=0, pointer=1, counters=0.
- sys_addr=7'h00, sys_domain=0.
- All gnt/valid/data/sys_start/timeout/busy outputs = 0.
REQ-020 Reset asserted mid-transaction SHALL discard that transaction; no valid or timeout SHALL follow release.
REQ-021 After release, the first request SHALL be serviced normally.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- req0=1, addr0=7'h10; sys_done after 20 WAIT cycles with sys_data=8'hA5 -> sys_start 1 cycle, sys_addr=7'h10, sys_domain=0; valid0 1 cycle, data0=8'hA5; data1=8'h00 and valid1=0 throughout.
- req0 and req1 high together after reset, addr1=7'h20 -> domain 0 served first; domain 1 granted after exactly SCRUB_CYCLES idle cycles, with sys_domain=1 and sys_addr=7'h20.
- req1 only, TIMEOUT=64, sys_done never -> timeout pulse on WAIT cycle 64; valid1=0; data1=8'h00; IDLE after 8 SCRUB cycles.
- rst pulsed on WAIT cycle 5 of a req0 transaction, then sys_done sent -> all outputs 0; no valid0; state IDLE.
- req0 held continuously with req1=0 -> back-to-back domain-0 transactions separated by 8 SCRUB cycles.
- sys_done pulse while in IDLE -> no valid or gnt activity.
- sys_done on the timeout terminal cycle -> valid asserted, timeout=0.

Source files
------------

// File: rtl/i2c_domain_arbiter.sv
// rtl/i2c_domain_arbiter.sv - two-domain round-robin owner arbiter for a shared I2C read sequencer
module i2c_domain_arbiter #(
    parameter logic [15:0] TIMEOUT      = 16'd4096,
    parameter logic [3:0]  SCRUB_CYCLES = 4'd8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic [6:0] addr0,
    output logic       gnt0,
    output logic       valid0,
    output logic [7:0] data0,
    input  logic       req1,
    input  logic [6:0] addr1,
    output logic       gnt1,
    output logic       valid1,
    output logic [7:0] data1,
    output logic       sys_start,
    output logic [6:0] sys_addr,
    output logic       sys_domain,
    input  logic       sys_done,
    input  logic [7:0] sys_data,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_WAIT, ST_SCRUB} state_t;

    state_t      state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [6:0]  addr_q, addr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [7:0]  data_q, data_d;
    logic        winner;
    logic        timeout_w;

    localparam logic [15:0] SCRUB_LAST = {12'd0, SCRUB_CYCLES} - 16'd1;
    localparam logic [15:0] WAIT_LAST  = TIMEOUT - 16'd1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            addr_q  <= 7'h00;
            cnt_q   <= 16'd0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    // On a tie the domain that was not served last takes the bus.
    always_comb begin
        if (req0 && req1) begin
            winner = ~last_q;
        end else begin
            winner = ~req0;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        last_d    = last_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        valid_d   = 1'b0;
        data_d    = 8'h00;
        timeout_w = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_START;
                    owner_d = winner;
                    addr_d  = winner ? addr1 : addr0;
                end
            end
            ST_START: begin
                state_d = ST_WAIT;
                cnt_d   = 16'd0;
            end
            ST_WAIT: begin
                // Completion beats a coincident terminal count.
                if (sys_done) begin
                    valid_d = 1'b1;
                    data_d  = sys_data;
                    state_d = ST_SCRUB;
                    last_d  = owner_q;
                    cnt_d   = 16'd0;
                end else if (cnt_q == WAIT_LAST) begin
                    timeout_w = 1'b1;
                    state_d   = ST_SCRUB;
                    last_d    = owner_q;
                    cnt_d     = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            ST_SCRUB: begin
                if (cnt_q == SCRUB_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    logic granted;
    assign granted    = (state_q == ST_START) || (state_q == ST_WAIT);
    assign gnt0       = granted && !owner_q;
    assign gnt1       = granted && owner_q;
    assign valid0     = valid_q && !owner_q;
    assign valid1     = valid_q && owner_q;
    assign data0      = valid0 ? data_q : 8'h00;
    assign data1      = valid1 ? data_q : 8'h00;
    assign sys_start  = (state_q == ST_START);
    assign sys_addr   = addr_q;
    assign sys_domain = owner_q;
    assign busy       = (state_q != ST_IDLE);
    assign timeout    = timeout_w;

endmodule

// File: tb/tb_i2c_domain_arbiter.sv
// tb/tb_i2c_domain_arbiter.sv - directed bench for i2c_domain_arbiter
module tb_i2c_domain_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0, req1, sys_done;
    logic [6:0] addr0, addr1;
    logic [7:0] sys_data;
    logic       gnt0, gnt1, valid0, valid1, sys_start, sys_domain, busy, timeout;
    logic [7:0] data0, data1;
    logic [6:0] sys_addr;

    int n_checks = 0;
    int n_fail   = 0;

    i2c_domain_arbiter #(.TIMEOUT(16'd64), .SCRUB_CYCLES(4'd8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .gnt0(gnt0), .valid0(valid0), .data0(data0),
        .req1(req1), .addr1(addr1), .gnt1(gnt1), .valid1(valid1), .data1(data1),
        .sys_start(sys_start), .sys_addr(sys_addr), .sys_domain(sys_domain),
        .sys_done(sys_done), .sys_data(sys_data), .busy(busy), .timeout(timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic apply_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
    endtask

    function automatic logic [31:0] outs_vec();
        return {gnt0, gnt1, valid0, valid1, sys_start, busy, timeout, data0, data1, sys_addr, sys_domain};
    endfunction

    task automatic test_reset;
        rst = 1'b1; req0 = 0; req1 = 0; addr0 = 7'h7f; addr1 = 7'h7f; sys_done = 0; sys_data = 8'h00;
        tick();
        n_checks++;
        if (outs_vec() !== 32'd0) begin
            n_fail++; $display("FAIL reset_outputs: got %h expected 0", outs_vec());
        end
        rst = 1'b0;
        tick();
        n_checks++;
        if (outs_vec() !== 32'd0) begin
            n_fail++; $display("FAIL reset_release_idle: got %h expected 0", outs_vec());
        end
    endtask

    task automatic test_single_read;
        int bad = 0;
        int starts;
        int scrub;
        req0 = 1; addr0 = 7'h10;
        tick();
        n_checks++;
        if ({sys_start, sys_addr, sys_domain, gnt0, gnt1} !== {1'b1, 7'h10, 1'b0, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL single_start: got %b/%h/%b/%b/%b expected 1/10/0/1/0",
                sys_start, sys_addr, sys_domain, gnt0, gnt1);
        end
        starts = 1;
        req0 = 0; addr0 = 7'h00;
        for (int k = 1; k <= 21; k++) begin
            tick();
            if (sys_start) starts++;
            if (!gnt0 || gnt1 || valid0 || valid1 || data0 !== 8'h00 || data1 !== 8'h00 || timeout) bad++;
        end
        sys_done = 1; sys_data = 8'hA5;
        tick();
        sys_done = 0; sys_data = 8'h00;
        n_checks++;
        if ({valid0, data0, gnt0, valid1, data1} !== {1'b1, 8'hA5, 1'b0, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL single_valid: got v0=%b d0=%h g0=%b v1=%b d1=%h expected 1 a5 0 0 00",
                valid0, data0, gnt0, valid1, data1);
        end
        scrub = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (sys_start) starts++;
            if (valid0 || valid1 || data0 !== 8'h00 || data1 !== 8'h00 || gnt0 || gnt1) bad++;
            if (!busy) break;
            scrub++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL single_steady: got %0d bad cycles expected 0", bad);
        end
        n_checks++;
        if (starts !== 1) begin
            n_fail++; $display("FAIL single_start_count: got %0d expected 1", starts);
        end
        n_checks++;
        if (scrub !== 8) begin
            n_fail++; $display("FAIL single_scrub_len: got %0d expected 8", scrub);
        end
    endtask

    task automatic test_tie;
        int scrub = 0;
        bit seen = 0;
        apply_reset();
        req0 = 1; req1 = 1; addr0 = 7'h11; addr1 = 7'h20;
        tick();
        n_checks++;
        if ({gnt0, gnt1, sys_domain, sys_addr} !== {1'b1, 1'b0, 1'b0, 7'h11}) begin
            n_fail++; $display("FAIL tie_first: got g0=%b g1=%b dom=%b addr=%h expected 1 0 0 11",
                gnt0, gnt1, sys_domain, sys_addr);
        end
        tick();
        sys_done = 1; sys_data = 8'h3C;
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid0, data0} !== {1'b1, 8'h3C}) begin
            n_fail++; $display("FAIL tie_valid0: got %b/%h expected 1/3c", valid0, data0);
        end
        scrub = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (gnt1) begin seen = 1; break; end
            if (busy && !gnt0) scrub++;
        end
        n_checks++;
        if (!seen || scrub !== 8) begin
            n_fail++; $display("FAIL tie_gap: got seen=%b scrub=%0d expected seen=1 scrub=8", seen, scrub);
        end
        n_checks++;
        if ({sys_domain, sys_addr, sys_start, gnt0} !== {1'b1, 7'h20, 1'b1, 1'b0}) begin
            n_fail++; $display("FAIL tie_second: got dom=%b addr=%h st=%b g0=%b expected 1 20 1 0",
                sys_domain, sys_addr, sys_start, gnt0);
        end
        req0 = 0; req1 = 0;
        tick();
        sys_done = 1; sys_data = 8'h5A;
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid1, data1, valid0, data0} !== {1'b1, 8'h5A, 1'b0, 8'h00}) begin
            n_fail++; $display("FAIL tie_valid1: got v1=%b d1=%h v0=%b d0=%h expected 1 5a 0 00",
                valid1, data1, valid0, data0);
        end
        wait_idle("tie_idle");
    endtask

    task automatic wait_idle(input string name);
        bit idle = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (!busy) begin idle = 1; break; end
        end
        n_checks++;
        if (!idle) begin
            n_fail++; $display("FAIL %s: got busy expected idle within 40 cycles", name);
        end
    endtask

    task automatic test_timeout;
        int early = 0;
        int scrub;
        req1 = 1; addr1 = 7'h33;
        tick();
        req1 = 0;
        for (int k = 1; k < 64; k++) begin
            tick();
            if (timeout || !gnt1) early++;
        end
        tick();
        n_checks++;
        if (early !== 0 || {timeout, gnt1} !== 2'b11) begin
            n_fail++; $display("FAIL timeout_pulse: got early=%0d to=%b g1=%b expected 0 1 1", early, timeout, gnt1);
        end
        tick();
        n_checks++;
        if ({timeout, valid1, data1, gnt1} !== {1'b0, 1'b0, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL timeout_after: got to=%b v1=%b d1=%h g1=%b expected 0 0 00 0",
                timeout, valid1, data1, gnt1);
        end
        scrub = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (!busy) break;
            if (valid1 || timeout) early++;
            scrub++;
        end
        n_checks++;
        if (scrub !== 8 || early !== 0) begin
            n_fail++; $display("FAIL timeout_scrub: got scrub=%0d stray=%0d expected 8 0", scrub, early);
        end
    endtask

    task automatic test_reset_mid;
        int bad = 0;
        req0 = 1; addr0 = 7'h44;
        tick();
        req0 = 0;
        for (int k = 0; k < 5; k++) tick();
        rst = 1;
        #1;
        n_checks++;
        if (outs_vec() !== 32'd0) begin
            n_fail++; $display("FAIL reset_mid_async: got %h expected 0", outs_vec());
        end
        tick();
        rst = 0;
        sys_done = 1; sys_data = 8'hFF;
        tick();
        sys_done = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (outs_vec() !== 32'd0) bad++;
        end
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", bad);
        end
        req0 = 1; addr0 = 7'h55;
        tick();
        req0 = 0;
        n_checks++;
        if ({gnt0, sys_start, sys_addr} !== {1'b1, 1'b1, 7'h55}) begin
            n_fail++; $display("FAIL reset_mid_resume: got g0=%b st=%b addr=%h expected 1 1 55", gnt0, sys_start, sys_addr);
        end
        tick();
        sys_done = 1; sys_data = 8'h66;
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid0, data0} !== {1'b1, 8'h66}) begin
            n_fail++; $display("FAIL reset_mid_data: got %b/%h expected 1/66", valid0, data0);
        end
        wait_idle("reset_mid_idle");
    endtask

    task automatic test_back_to_back;
        int scrub;
        bit seen = 0;
        req0 = 1; req1 = 0; addr0 = 7'h66;
        tick();
        tick();
        sys_done = 1; sys_data = 8'h81;
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid0, data0} !== {1'b1, 8'h81}) begin
            n_fail++; $display("FAIL b2b_first: got %b/%h expected 1/81", valid0, data0);
        end
        scrub = 1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (gnt0) begin seen = 1; break; end
            if (busy) scrub++;
        end
        n_checks++;
        if (!seen || scrub !== 8 || !sys_start || sys_addr !== 7'h66) begin
            n_fail++; $display("FAIL b2b_second: got seen=%b scrub=%0d st=%b addr=%h expected 1 8 1 66",
                seen, scrub, sys_start, sys_addr);
        end
        req0 = 0;
        tick();
        sys_done = 1; sys_data = 8'h82;
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid0, data0} !== {1'b1, 8'h82}) begin
            n_fail++; $display("FAIL b2b_second_data: got %b/%h expected 1/82", valid0, data0);
        end
        wait_idle("b2b_idle");
    endtask

    task automatic test_done_in_idle;
        int bad = 0;
        sys_done = 1; sys_data = 8'h77;
        for (int k = 0; k < 3; k++) begin
            tick();
            if (gnt0 || gnt1 || valid0 || valid1 || busy || data0 !== 8'h00 || data1 !== 8'h00) bad++;
        end
        sys_done = 0;
        tick();
        if (valid0 || valid1 || busy) bad++;
        n_checks++;
        if (bad !== 0) begin
            n_fail++; $display("FAIL done_in_idle: got %0d active cycles expected 0", bad);
        end
    endtask

    task automatic test_coincide;
        req1 = 1; addr1 = 7'h12;
        tick();
        req1 = 0;
        for (int k = 1; k < 64; k++) tick();
        tick();
        sys_done = 1; sys_data = 8'hC3;
        #1;
        n_checks++;
        if (timeout !== 1'b0) begin
            n_fail++; $display("FAIL coincide_timeout: got %b expected 0", timeout);
        end
        tick();
        sys_done = 0;
        n_checks++;
        if ({valid1, data1, timeout} !== {1'b1, 8'hC3, 1'b0}) begin
            n_fail++; $display("FAIL coincide_valid: got v1=%b d1=%h to=%b expected 1 c3 0", valid1, data1, timeout);
        end
        wait_idle("coincide_idle");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        test_done_in_idle();
        test_coincide();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
